// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the two-port RAM arbiter: FSM states, port ids and
// the legal range of the access length.
package ram_port_arbiter_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ACCESS  = 2'd1,
      S_RECOVER = 2'd2
   } state_t;

   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

   localparam int ACC_CYC_MIN = 1;
   localparam int ACC_CYC_MAX = 4;

   function automatic bit acc_cyc_legal(input int n);
      return (n >= ACC_CYC_MIN) && (n <= ACC_CYC_MAX);
   endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_arb2.sv
// Two-way round-robin pick. The pointer only moves under contention, and then
// it moves to the loser so the next contended grant goes the other way.
module ram_port_arbiter_rr_arb2
   import ram_port_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       load,
   output logic       grant
);

   logic ptr;

   always_comb begin
      case (req)
         2'b01:   grant = PORT_A;
         2'b10:   grant = PORT_B;
         default: grant = ptr;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         ptr <= PORT_A;
      else if (load && (req == 2'b11))
         ptr <= ~grant;
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one RAM between port A and port B: round-robin grant, req/done
// handshake, and active-low CS/WR sequencing IDLE -> ACCESS -> RECOVER.
module ram_port_arbiter
   import ram_port_arbiter_pkg::*;
#(
   parameter int AW      = 8,
   parameter int DW      = 8,
   parameter int ACC_CYC = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          a_req,
   input  logic          a_we,
   input  logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_wdata,
   output logic [DW-1:0] a_rdata,
   output logic          a_done,
   input  logic          b_req,
   input  logic          b_we,
   input  logic [AW-1:0] b_addr,
   input  logic [DW-1:0] b_wdata,
   output logic [DW-1:0] b_rdata,
   output logic          b_done,
   output logic          ram_cs,
   output logic          ram_wr,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_din,
   input  logic [DW-1:0] ram_dout,
   output logic          busy
);

   if (!acc_cyc_legal(ACC_CYC)) begin : g_acc_cyc_check
      $error("ram_port_arbiter: ACC_CYC must be 1..4");
   end

   localparam logic [1:0] LAST_CNT = 2'(ACC_CYC - 1);

   state_t     state, state_nxt;
   logic [1:0] cnt;
   logic       gnt_id;
   logic       arb_grant;
   logic       start;
   logic       acc_last;

   assign start    = (state == S_IDLE) && (a_req || b_req);
   assign acc_last = (state == S_ACCESS) && (cnt == LAST_CNT);

   ram_port_arbiter_rr_arb2 u_arb (
      .clk   (clk),
      .rst   (rst),
      .req   ({b_req, a_req}),
      .load  (start),
      .grant (arb_grant)
   );

   always_comb begin
      // NOTE: default first so every path assigns state_nxt and no latch is inferred.
      state_nxt = state;
      case (state)
         S_IDLE:    if (start) state_nxt = S_ACCESS;
         S_ACCESS:  if (acc_last) state_nxt = S_RECOVER;
         S_RECOVER: state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking so every register in this process updates from pre-edge values.
      if (rst)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   // The winner's request is captured straight into the RAM-side registers,
   // which then stay frozen until the access finishes.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         gnt_id   <= PORT_A;
         ram_cs   <= 1'b1;
         ram_wr   <= 1'b1;
         ram_addr <= '0;
         ram_din  <= '0;
         a_rdata  <= '0;
         b_rdata  <= '0;
         a_done   <= 1'b0;
         b_done   <= 1'b0;
         busy     <= 1'b0;
      end else begin
         a_done <= 1'b0;
         b_done <= 1'b0;
         busy   <= (state_nxt != S_IDLE);
         case (state)
            S_IDLE: begin
               if (start) begin
                  gnt_id   <= arb_grant;
                  cnt      <= '0;
                  ram_cs   <= 1'b0;
                  ram_wr   <= (arb_grant == PORT_B) ? ~b_we    : ~a_we;
                  ram_addr <= (arb_grant == PORT_B) ? b_addr  : a_addr;
                  ram_din  <= (arb_grant == PORT_B) ? b_wdata : a_wdata;
               end
            end
            S_ACCESS: begin
               cnt <= cnt + 2'd1;
               if (acc_last) begin
                  ram_cs <= 1'b1;
                  ram_wr <= 1'b1;
                  if (gnt_id == PORT_A) begin
                     a_done <= 1'b1;
                     if (ram_wr) a_rdata <= ram_dout;
                  end else begin
                     b_done <= 1'b1;
                     if (ram_wr) b_rdata <= ram_dout;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench: two arbiters (ACC_CYC=1 and 3), each with a RAM model,
// checked against a reference memory and a round-robin pointer model.
module tb_ram_port_arbiter;

   logic clk = 1'b0;
   always #10 clk = ~clk;

   logic       rst      [2];
   logic       a_req    [2];
   logic       a_we     [2];
   logic [7:0] a_addr   [2];
   logic [7:0] a_wdata  [2];
   logic [7:0] a_rdata  [2];
   logic       a_done   [2];
   logic       b_req    [2];
   logic       b_we     [2];
   logic [7:0] b_addr   [2];
   logic [7:0] b_wdata  [2];
   logic [7:0] b_rdata  [2];
   logic       b_done   [2];
   logic       ram_cs   [2];
   logic       ram_wr   [2];
   logic [7:0] ram_addr [2];
   logic [7:0] ram_din  [2];
   logic [7:0] ram_dout [2];
   logic       busy     [2];

   logic [7:0] mem     [2][256];
   logic [7:0] ref_mem [2][256];
   bit         mem_ready;
   logic       ptr     [2];
   logic [7:0] rd_exp  [2][2];

   int n_tests = 0;
   int n_fail  = 0;

   ram_port_arbiter #(.AW(8), .DW(8), .ACC_CYC(1)) dut1 (
      .clk(clk), .rst(rst[0]),
      .a_req(a_req[0]), .a_we(a_we[0]), .a_addr(a_addr[0]), .a_wdata(a_wdata[0]),
      .a_rdata(a_rdata[0]), .a_done(a_done[0]),
      .b_req(b_req[0]), .b_we(b_we[0]), .b_addr(b_addr[0]), .b_wdata(b_wdata[0]),
      .b_rdata(b_rdata[0]), .b_done(b_done[0]),
      .ram_cs(ram_cs[0]), .ram_wr(ram_wr[0]), .ram_addr(ram_addr[0]), .ram_din(ram_din[0]),
      .ram_dout(ram_dout[0]), .busy(busy[0])
   );

   ram_port_arbiter #(.AW(8), .DW(8), .ACC_CYC(3)) dut3 (
      .clk(clk), .rst(rst[1]),
      .a_req(a_req[1]), .a_we(a_we[1]), .a_addr(a_addr[1]), .a_wdata(a_wdata[1]),
      .a_rdata(a_rdata[1]), .a_done(a_done[1]),
      .b_req(b_req[1]), .b_we(b_we[1]), .b_addr(b_addr[1]), .b_wdata(b_wdata[1]),
      .b_rdata(b_rdata[1]), .b_done(b_done[1]),
      .ram_cs(ram_cs[1]), .ram_wr(ram_wr[1]), .ram_addr(ram_addr[1]), .ram_din(ram_din[1]),
      .ram_dout(ram_dout[1]), .busy(busy[1])
   );

   function automatic logic [7:0] init_val(input bit g, input logic [7:0] i);
      if (i == 8'h20) return 8'h3C;
      return i * 8'd7 + (g ? 8'd13 : 8'd0) + 8'h5A;
   endfunction

   // RAM models: contents seeded on the first edge, write while CS and WR are low.
   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < 256; i++) begin
            mem[0][8'(i)] <= init_val(1'b0, 8'(i));
            mem[1][8'(i)] <= init_val(1'b1, 8'(i));
         end
         mem_ready <= 1'b1;
      end else begin
         if (ram_cs[0] == 1'b0 && ram_wr[0] == 1'b0) mem[0][ram_addr[0]] <= ram_din[0];
         if (ram_cs[1] == 1'b0 && ram_wr[1] == 1'b0) mem[1][ram_addr[1]] <= ram_din[1];
      end
   end
   assign ram_dout[0] = mem[0][ram_addr[0]];
   assign ram_dout[1] = mem[1][ram_addr[1]];

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic int acc_of(input bit d);
      return d ? 3 : 1;
   endfunction

   function automatic logic done_of(input bit d, input bit p);
      return p ? b_done[d] : a_done[d];
   endfunction

   function automatic logic [7:0] rdata_of(input bit d, input bit p);
      return p ? b_rdata[d] : a_rdata[d];
   endfunction

   task automatic drive(input bit d, input bit p, input logic req, input logic we,
                        input logic [7:0] addr, input logic [7:0] wd);
      if (p) begin
         b_req[d] = req; b_we[d] = we; b_addr[d] = addr; b_wdata[d] = wd;
      end else begin
         a_req[d] = req; a_we[d] = we; a_addr[d] = addr; a_wdata[d] = wd;
      end
   endtask

   task automatic invariants(input bit d);
      if (ram_wr[d] == 1'b0) check("wr_needs_cs", 32'(ram_cs[d]), 0);
   endtask

   // Reference bookkeeping when port p's DONE is seen.
   task automatic complete(input bit d, input bit p, input logic we, input logic [7:0] addr,
                           input logic [7:0] wd);
      if (we) begin
         ref_mem[d][addr] = wd;
         check("rdata_hold_own", 32'(rdata_of(d, p)), 32'(rd_exp[d][p]));
      end else begin
         check("rdata", 32'(rdata_of(d, p)), 32'(ref_mem[d][addr]));
         rd_exp[d][p] = ref_mem[d][addr];
      end
      check("rdata_hold_other", 32'(rdata_of(d, !p)), 32'(rd_exp[d][!p]));
   endtask

   task automatic reset_checks(input bit d);
      check("rst_cs",      32'(ram_cs[d]),   1);
      check("rst_wr",      32'(ram_wr[d]),   1);
      check("rst_addr",    32'(ram_addr[d]), 0);
      check("rst_din",     32'(ram_din[d]),  0);
      check("rst_a_done",  32'(a_done[d]),   0);
      check("rst_b_done",  32'(b_done[d]),   0);
      check("rst_busy",    32'(busy[d]),     0);
      check("rst_a_rdata", 32'(a_rdata[d]),  0);
      check("rst_b_rdata", 32'(b_rdata[d]),  0);
   endtask

   task automatic model_reset(input bit d);
      ptr[d]       = 1'b0;
      rd_exp[d][0] = 8'h00;
      rd_exp[d][1] = 8'h00;
   endtask

   task automatic do_reset(input bit d);
      @(negedge clk);
      rst[d] = 1'b1;
      drive(d, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      drive(d, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
      repeat (2) @(negedge clk);
      rst[d] = 1'b0;
      model_reset(d);
      reset_checks(d);
   endtask

   // One access from a single port, timed from the edge that first samples REQ.
   task automatic xfer(input bit d, input bit p, input logic we, input logic [7:0] addr,
                       input logic [7:0] wd);
      int n = 0;
      int cs_low = 0;
      int wr_low = 0;
      bit got = 1'b0;
      @(negedge clk);
      drive(d, p, 1'b1, we, addr, wd);
      while (!got && n < 40) begin
         @(negedge clk);
         n++;
         invariants(d);
         if (ram_cs[d] == 1'b0) begin
            cs_low++;
            check("xfer_addr_hold", 32'(ram_addr[d]), 32'(addr));
         end
         if (ram_wr[d] == 1'b0) wr_low++;
         check("xfer_other_done", 32'(done_of(d, !p)), 0);
         got = (done_of(d, p) == 1'b1);
      end
      check("xfer_done",    32'(got), 1);
      check("xfer_latency", n, acc_of(d) + 1);
      check("xfer_cs_low",  cs_low, acc_of(d));
      check("xfer_wr_low",  wr_low, we ? acc_of(d) : 0);
      check("xfer_busy",    32'(busy[d]), 1);
      complete(d, p, we, addr, wd);
      drive(d, p, 1'b0, 1'b0, 8'h00, 8'h00);
   endtask

   // Requests raised together; each port drops REQ on its own DONE.
   task automatic round(input bit d, input bit ra, input bit rb,
                        input logic wea, input logic [7:0] aa, input logic [7:0] da,
                        input logic web, input logic [7:0] ab, input logic [7:0] db);
      bit first;
      bit exp_p;
      bit p;
      int n = 0;
      int served = 0;
      int want = int'(ra) + int'(rb);
      if (ra && rb) begin
         first  = ptr[d];
         ptr[d] = !first;
      end else begin
         first = rb;
      end
      @(negedge clk);
      if (ra) drive(d, 1'b0, 1'b1, wea, aa, da);
      if (rb) drive(d, 1'b1, 1'b1, web, ab, db);
      while (served < want && n < 60) begin
         @(negedge clk);
         n++;
         invariants(d);
         for (int k = 0; k < 2; k++) begin
            p = (k == 1);
            if (done_of(d, p) == 1'b1) begin
               exp_p = (served == 0) ? first : !first;
               check("rr_order",  32'(p), 32'(exp_p));
               check("rr_timing", n, (served == 0) ? acc_of(d) + 1 : 2 * acc_of(d) + 3);
               complete(d, p, p ? web : wea, p ? ab : aa, p ? db : da);
               drive(d, p, 1'b0, 1'b0, 8'h00, 8'h00);
               served++;
            end
         end
      end
      check("rr_served", served, want);
   endtask

   // Both ports hold REQ across six accesses: A writes addr, B reads it back.
   task automatic fairness(input logic [7:0] addr, input logic [7:0] wd);
      bit exp_p;
      bit p;
      int n = 0;
      int last = 0;
      int served = 0;
      @(negedge clk);
      drive(0, 1'b0, 1'b1, 1'b1, addr, wd);
      drive(0, 1'b1, 1'b1, 1'b0, addr, 8'h00);
      while (served < 6 && n < 100) begin
         @(negedge clk);
         n++;
         invariants(0);
         for (int k = 0; k < 2; k++) begin
            p = (k == 1);
            if (done_of(0, p) == 1'b1) begin
               exp_p  = ptr[0];
               ptr[0] = !exp_p;
               check("fair_order", 32'(p), 32'(exp_p));
               check("fair_gap", n - last, (served == 0) ? acc_of(0) + 1 : acc_of(0) + 2);
               last = n;
               complete(0, p, !p, addr, wd);
               served++;
               if (served == 6) begin
                  drive(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
                  drive(0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
               end
            end
         end
      end
      check("fair_served", served, 6);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int pat;
      bit d;
      for (int g = 0; g < 2; g++) begin
         for (int i = 0; i < 256; i++) ref_mem[g][i] = init_val(g == 1, 8'(i));
      end
      rst[0] = 1'b1;
      rst[1] = 1'b1;
      for (int g = 0; g < 2; g++) begin
         drive(g == 1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
         drive(g == 1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
      end
      repeat (2) @(negedge clk);
      rst[0] = 1'b0;
      rst[1] = 1'b0;
      model_reset(1'b0);
      model_reset(1'b1);
      reset_checks(1'b0);
      reset_checks(1'b1);

      // Single write then read on port A.
      xfer(1'b0, 1'b0, 1'b1, 8'h02, 8'h0F);
      xfer(1'b0, 1'b0, 1'b0, 8'h02, 8'h00);
      check("t2_rdata", 32'(a_rdata[0]), 32'h0F);

      // Contention straight after reset: A first, then B.
      do_reset(1'b0);
      round(1'b0, 1'b1, 1'b1, 1'b1, 8'h10, 8'h55, 1'b1, 8'h11, 8'hAA);
      xfer(1'b0, 1'b0, 1'b0, 8'h10, 8'h00);
      check("t3_a_rdata", 32'(a_rdata[0]), 32'h55);
      xfer(1'b0, 1'b1, 1'b0, 8'h11, 8'h00);
      check("t3_b_rdata", 32'(b_rdata[0]), 32'hAA);

      do_reset(1'b0);
      fairness(8'h30, 8'h9D);

      // Randomized traffic on both builds.
      repeat (60) begin
         d   = ($urandom_range(0, 1) == 1);
         pat = $urandom_range(1, 3);
         round(d, pat[0], pat[1],
               ($urandom_range(0, 1) == 1), 8'($urandom_range(0, 15)), 8'($urandom),
               ($urandom_range(0, 1) == 1), 8'($urandom_range(0, 15)), 8'($urandom));
      end
      repeat (10) begin
         d = ($urandom_range(0, 1) == 1);
         xfer(d, ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
              8'($urandom_range(0, 15)), 8'($urandom));
      end

      // ACC_CYC=3 read of the preloaded location.
      xfer(1'b1, 1'b1, 1'b0, 8'h20, 8'h00);
      check("t5_b_rdata", 32'(b_rdata[1]), 32'h3C);

      // Reset during the first ACCESS cycle of an A write.
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b1, 1'b1, 8'h44, 8'hC3);
      @(negedge clk);
      check("t6_in_access", 32'(ram_cs[1]), 0);
      rst[1] = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      @(negedge clk);
      rst[1] = 1'b0;
      model_reset(1'b1);
      check("t6_cs",     32'(ram_cs[1]), 1);
      check("t6_wr",     32'(ram_wr[1]), 1);
      check("t6_a_done", 32'(a_done[1]), 0);
      check("t6_busy",   32'(busy[1]),   0);
      repeat (4) begin
         @(negedge clk);
         check("t6_no_done", 32'(a_done[1]), 0);
      end
      xfer(1'b1, 1'b0, 1'b1, 8'h44, 8'hC3);
      xfer(1'b1, 1'b0, 1'b0, 8'h44, 8'h00);
      check("t6_readback", 32'(a_rdata[1]), 32'hC3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
